// File: rtl/nx4_status_pkg.sv
// Shared defaults and sizing helpers for the LED status monitor block.
package nx4_status_pkg;

  localparam int DEF_N_PANELS    = 1;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_WDOG_CYCLES = 1048576;
  localparam int DEF_XERR_FILT   = 4;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xerr_filter.sv
// One XERR channel: two-flop synchroniser, low-time filter and sticky error flag.
module xerr_filter
  import nx4_status_pkg::*;
#(
  parameter int XERR_FILT = DEF_XERR_FILT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic xerr,
  input  logic err_clear,
  output logic err_flag
);

  localparam int FW = cnt_width(XERR_FILT);
  localparam logic [FW-1:0] FILT_MAX = FW'(XERR_FILT);

  logic          sync_p0;
  logic          sync_p1;
  logic [FW-1:0] filt_cnt;
  logic          set_cond;

  function automatic logic [FW-1:0] filt_sat_inc(input logic [FW-1:0] v);
    return (v == FILT_MAX) ? v : v + FW'(1);
  endfunction

  // Flag sets on the same edge the counter lands on (or sits at) its limit,
  // so a channel still held low re-asserts straight through an err_clear.
  assign set_cond = ~sync_p1 && (filt_sat_inc(filt_cnt) == FILT_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= 1'b1;
      sync_p1  <= 1'b1;
      filt_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      // stage p0 -> p1: metastability settling
      sync_p0  <= xerr;
      sync_p1  <= sync_p0;
      // stage p1 -> filter/flag
      filt_cnt <= sync_p1 ? '0 : filt_sat_inc(filt_cnt);
      if (set_cond)
        err_flag <= 1'b1;
      else if (err_clear)
        err_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/led_status_monitor.sv
// LED panel status monitor: blank heartbeat counter, blank watchdog and
// per-panel filtered sticky XERR flags driving the status LEDs.
module led_status_monitor
  import nx4_status_pkg::*;
#(
  parameter int N_PANELS    = DEF_N_PANELS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HB_BIT      = CNT_W - 1,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES,
  parameter int XERR_FILT   = DEF_XERR_FILT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                led_blank,
  input  logic [N_PANELS-1:0] led_xerr,
  input  logic                err_clear,
  output logic [CNT_W-1:0]    blank_count,
  output logic [N_PANELS-1:0] err_flags,
  output logic                status_yellow,
  output logic                status_orange,
  output logic                status_red,
  output logic                cpld_p8,
  output logic                cpld_p2
);

  localparam int WW = cnt_width(WDOG_CYCLES);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  logic          blank_p0;
  logic          blank_edge;
  logic [WW-1:0] wdog_cnt;

  function automatic logic [WW-1:0] wdog_sat_inc(input logic [WW-1:0] v);
    return (v == WDOG_MAX) ? v : v + WW'(1);
  endfunction

  // Previous sample resets low, so BLANK already high at reset release is an edge.
  assign blank_edge = led_blank & ~blank_p0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank_p0      <= 1'b0;
      blank_count   <= '0;
      wdog_cnt      <= '0;
      status_orange <= 1'b0;
    end else begin
      // stage p0: edge detect feeds counter and watchdog
      blank_p0 <= led_blank;
      if (blank_edge) begin
        blank_count   <= blank_count + CNT_W'(1);
        wdog_cnt      <= '0;
        status_orange <= 1'b0;
      end else begin
        wdog_cnt <= wdog_sat_inc(wdog_cnt);
        if (wdog_cnt == WDOG_MAX)
          status_orange <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_PANELS; g++) begin : g_panel
    xerr_filter #(
      .XERR_FILT(XERR_FILT)
    ) u_filter (
      .clock    (clock),
      .reset_n  (reset_n),
      .xerr     (led_xerr[g]),
      .err_clear(err_clear),
      .err_flag (err_flags[g])
    );
  end

  assign status_yellow = blank_count[HB_BIT];
  assign status_red    = |err_flags;
  assign cpld_p8       = led_blank;
  assign cpld_p2       = ~status_orange;

endmodule

// File: tb/tb_led_status_monitor.sv
// Directed bench for led_status_monitor: counter wrap, watchdog, XERR filter, clear and reset.
module tb_led_status_monitor;

  localparam int N_PANELS    = 3;
  localparam int CNT_W       = 4;
  localparam int HB_BIT      = 3;
  localparam int WDOG_CYCLES = 100;
  localparam int XERR_FILT   = 4;

  logic                clock;
  logic                reset_n;
  logic                led_blank;
  logic [N_PANELS-1:0] led_xerr;
  logic                err_clear;
  logic [CNT_W-1:0]    blank_count;
  logic [N_PANELS-1:0] err_flags;
  logic                status_yellow;
  logic                status_orange;
  logic                status_red;
  logic                cpld_p8;
  logic                cpld_p2;

  int checks   = 0;
  int failures = 0;

  led_status_monitor #(
    .N_PANELS   (N_PANELS),
    .CNT_W      (CNT_W),
    .HB_BIT     (HB_BIT),
    .WDOG_CYCLES(WDOG_CYCLES),
    .XERR_FILT  (XERR_FILT)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .led_blank    (led_blank),
    .led_xerr     (led_xerr),
    .err_clear    (err_clear),
    .blank_count  (blank_count),
    .err_flags    (err_flags),
    .status_yellow(status_yellow),
    .status_orange(status_orange),
    .status_red   (status_red),
    .cpld_p8      (cpld_p8),
    .cpld_p2      (cpld_p2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    led_blank = 1'b0;
    led_xerr  = 3'b111;
    err_clear = 1'b0;
    #2;
    checks++;
    if (blank_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", blank_count); end
    checks++;
    if (err_flags !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", err_flags); end
    checks++;
    if ({status_yellow, status_orange, status_red, cpld_p2, cpld_p8} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_status got=%b exp=00010", {status_yellow, status_orange, status_red, cpld_p2, cpld_p8});
    end
    led_blank = 1'b1;
    #1;
    checks++;
    if (cpld_p8 !== 1'b1) begin failures++; $display("FAIL cpld_p8_copy got=%b exp=1", cpld_p8); end
    tick();
    tick();
    checks++;
    if (blank_count !== 4'd0) begin failures++; $display("FAIL count_held_in_reset got=%0d exp=0", blank_count); end
    reset_n = 1'b1;
    tick();
    checks++;
    if (blank_count !== 4'd1) begin failures++; $display("FAIL blank_high_at_release got=%0d exp=1", blank_count); end
    tick();
    checks++;
    if (blank_count !== 4'd1) begin failures++; $display("FAIL blank_level_no_edge got=%0d exp=1", blank_count); end
    led_blank = 1'b0;
    tick();
  endtask

  task automatic test_blank_count();
    logic [3:0] exp_cnt;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      led_blank = 1'b1;
      tick();
      led_blank = 1'b0;
      tick();
      exp_cnt = 4'(i);
      checks++;
      if (blank_count !== exp_cnt) begin failures++; $display("FAIL blank_count pulse=%0d got=%0d exp=%0d", i, blank_count, exp_cnt); end
      checks++;
      if (status_yellow !== exp_cnt[3]) begin failures++; $display("FAIL heartbeat pulse=%0d got=%b exp=%b", i, status_yellow, exp_cnt[3]); end
    end
    checks++;
    if (status_orange !== 1'b0 || cpld_p2 !== 1'b1) begin
      failures++;
      $display("FAIL wdog_quiet got=%b%b exp=01", status_orange, cpld_p2);
    end
  endtask

  task automatic test_watchdog();
    led_blank = 1'b1;
    tick();
    led_blank = 1'b0;
    repeat (100) tick();
    checks++;
    if (status_orange !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", status_orange); end
    tick();
    checks++;
    if (status_orange !== 1'b1 || cpld_p2 !== 1'b0) begin
      failures++;
      $display("FAIL wdog_timeout orange/p2 got=%b%b exp=10", status_orange, cpld_p2);
    end
    repeat (5) tick();
    led_blank = 1'b1;
    #1;
    checks++;
    if (status_orange !== 1'b1) begin failures++; $display("FAIL wdog_hold_before_edge got=%b exp=1", status_orange); end
    tick();
    led_blank = 1'b0;
    checks++;
    if (status_orange !== 1'b0 || cpld_p2 !== 1'b1) begin
      failures++;
      $display("FAIL wdog_clear orange/p2 got=%b%b exp=01", status_orange, cpld_p2);
    end
    // Edge lands exactly when the counter reaches its limit: no timeout.
    repeat (100) tick();
    led_blank = 1'b1;
    tick();
    led_blank = 1'b0;
    checks++;
    if (status_orange !== 1'b0) begin failures++; $display("FAIL wdog_edge_priority got=%b exp=0", status_orange); end
    repeat (3) tick();
    checks++;
    if (status_orange !== 1'b0) begin failures++; $display("FAIL wdog_restart got=%b exp=0", status_orange); end
  endtask

  task automatic test_xerr_filter();
    led_xerr = 3'b101;
    repeat (3) tick();
    led_xerr = 3'b111;
    repeat (8) tick();
    checks++;
    if (err_flags !== 3'b000 || status_red !== 1'b0) begin
      failures++;
      $display("FAIL filter_short got=%b red=%b exp=000 red=0", err_flags, status_red);
    end
    led_xerr = 3'b101;
    repeat (4) tick();
    led_xerr = 3'b111;
    tick();
    checks++;
    if (err_flags !== 3'b000) begin failures++; $display("FAIL filter_latency_early got=%b exp=000", err_flags); end
    tick();
    checks++;
    if (err_flags !== 3'b010 || status_red !== 1'b1) begin
      failures++;
      $display("FAIL filter_set got=%b red=%b exp=010 red=1", err_flags, status_red);
    end
    repeat (8) tick();
    checks++;
    if (err_flags !== 3'b010) begin failures++; $display("FAIL flag_sticky got=%b exp=010", err_flags); end
  endtask

  task automatic test_err_clear();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (err_flags !== 3'b000 || status_red !== 1'b0) begin
      failures++;
      $display("FAIL clear_released got=%b red=%b exp=000 red=0", err_flags, status_red);
    end
    led_xerr = 3'b001;
    repeat (8) tick();
    checks++;
    if (err_flags !== 3'b110) begin failures++; $display("FAIL two_channels got=%b exp=110", err_flags); end
    led_xerr = 3'b101;
    repeat (4) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    checks++;
    if (err_flags !== 3'b010 || status_red !== 1'b1) begin
      failures++;
      $display("FAIL clear_set_wins got=%b red=%b exp=010 red=1", err_flags, status_red);
    end
  endtask

  task automatic test_async_reset();
    led_blank = 1'b1;
    tick();
    led_blank = 1'b0;
    repeat (105) tick();
    checks++;
    if (status_orange !== 1'b1 || err_flags !== 3'b010) begin
      failures++;
      $display("FAIL pre_reset_state orange=%b flags=%b exp orange=1 flags=010", status_orange, err_flags);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (blank_count !== 4'd0 || err_flags !== 3'b000) begin
      failures++;
      $display("FAIL async_reset count=%0d flags=%b exp count=0 flags=000", blank_count, err_flags);
    end
    checks++;
    if ({status_yellow, status_orange, status_red, cpld_p2} !== 4'b0001) begin
      failures++;
      $display("FAIL async_reset_status got=%b exp=0001", {status_yellow, status_orange, status_red, cpld_p2});
    end
    led_xerr = 3'b111;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    checks++;
    if (err_flags !== 3'b000) begin failures++; $display("FAIL no_spurious_after_release got=%b exp=000", err_flags); end
  endtask

  initial begin
    test_reset();
    test_blank_count();
    test_watchdog();
    test_xerr_filter();
    test_err_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
